// File: rtl/sdpb_ram_param.sv
// -----------------------------------------------------------------------------
// sdpb_ram_param
// Parametrised single-clock simple dual-port RAM. It has one write port with
// byte enables and one read port. A clear FSM zeroes every word after reset.
// The read path has a valid pulse and an optional second output register,
// gated by oce.
//
// Optional feature (compile-time macro):
//   SDPB_RAM_BYPASS_EN  defined   : write-first forwarding on same-address
//                                   read/write (per byte lane)
//                       undefined : read-before-write (old word returned)
//
// Parameters:
//   DATA_W     data width, multiple of BYTE_W
//   BYTE_W     bits per byte-enable lane
//   ADDR_W     address width, DEPTH = 2**ADDR_W
//   READ_LAT   1 = single read register, 2 = extra oce-gated output register
//   INIT_CLEAR 1 = zero all words after every reset
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   init_busy  high while the clear FSM runs; both ports are ignored meanwhile
//   wr_en      write request
//   wr_addr    write word address
//   wr_data    write data
//   wr_be      byte enables
//   rd_en      read request
//   rd_addr    read word address
//   oce        output register enable (READ_LAT=2 only)
//   rd_data    read data
//   rd_valid   one-cycle pulse when rd_data carries newly delivered data
// -----------------------------------------------------------------------------
module sdpb_ram_param #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BYTE_W     = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       init_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/BYTE_W-1:0]   wr_be,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic                       oce,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid
);

  localparam int unsigned NB    = DATA_W / BYTE_W;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                init_busy_q;
  logic                ready;
  logic                rd_accept;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  // Clear FSM. A reset during the clear restarts it from address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q   <= '0;
      init_busy_q <= (INIT_CLEAR != 0);
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (&clr_cnt_q) begin
            state_q     <= ST_READY;
            init_busy_q <= 1'b0;
          end
        end
        ST_READY: state_q <= ST_READY;
        default:  state_q <= ST_READY;
      endcase
    end
  end

  assign ready     = (state_q == ST_READY);
  assign init_busy = init_busy_q;
  assign rd_accept = rd_en & ready;

  // Storage. It has no reset, so it can map onto block RAM. The clear port
  // shares the write port.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) mem_q[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read word. By default the array is read before the write commits, so the
  // old word is returned. With forwarding, the lanes being written are taken
  // from wr_data.
  always_comb begin
    rd_word = mem_q[rd_addr];
`ifdef SDPB_RAM_BYPASS_EN
    if (wr_en && ready && (wr_addr == rd_addr)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
      end
    end
`endif
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] s1_d_q;
      logic              s1_v_q;

      // Stage 1 always captures accepted reads. If it still holds undelivered
      // data while oce is low, the new read overwrites it. The output stage
      // only moves when oce is high.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_d_q     <= '0;
          s1_v_q     <= 1'b0;
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          if (rd_accept) begin
            s1_d_q <= rd_word;
            s1_v_q <= 1'b1;
          end else if (oce) begin
            s1_v_q <= 1'b0;
          end
          if (oce) begin
            rd_data_q  <= s1_d_q;
            rd_valid_q <= s1_v_q;
          end else begin
            rd_valid_q <= 1'b0;
          end
        end
      end
    end else begin : g_lat1
      logic unused_oce;
      assign unused_oce = oce;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          if (rd_accept) rd_data_q <= rd_word;
          rd_valid_q <= rd_accept;
        end
      end
    end
  endgenerate

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sdpb_ram_param.sv
// -----------------------------------------------------------------------------
// tb_sdpb_ram_param
// Two instances share the write port, the read address and reset: u_lat1
// (READ_LAT=1) and u_lat2 (READ_LAT=2). Expected read results are queued when
// a read is issued, together with the cycle in which they are due. Monitors
// compare on every rd_valid pulse.
// -----------------------------------------------------------------------------
module tb_sdpb_ram_param;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en1 = 1'b0;
  logic        rd_en2 = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic        oce1 = 1'b1;
  logic        oce2 = 1'b1;
  logic        busy1, busy2;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q1[$];
  exp_t q2[$];

  sdpb_ram_param #(.DATA_W(32), .BYTE_W(8), .ADDR_W(3), .READ_LAT(1), .INIT_CLEAR(1)) u_lat1 (
    .clk(clk), .reset(reset), .init_busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en1), .rd_addr(rd_addr), .oce(oce1),
    .rd_data(rd_data1), .rd_valid(rd_valid1)
  );

  sdpb_ram_param #(.DATA_W(32), .BYTE_W(8), .ADDR_W(3), .READ_LAT(2), .INIT_CLEAR(1)) u_lat2 (
    .clk(clk), .reset(reset), .init_busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en2), .rd_addr(rd_addr), .oce(oce2),
    .rd_data(rd_data2), .rd_valid(rd_valid2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (rd_valid1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL lat1_unexpected_valid actual=valid(data=0x%08h) required=no_valid cycle=%0d", rd_data1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("lat1_rd_data", rd_data1, e.d);
        chk("lat1_rd_cycle", cyc, e.due);
      end
    end
    if (rd_valid2) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL lat2_unexpected_valid actual=valid(data=0x%08h) required=no_valid cycle=%0d", rd_data2, cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("lat2_rd_data", rd_data2, e.d);
        chk("lat2_rd_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd1(input logic [2:0] a, input logic [31:0] e);
    rd_en1 = 1'b1; rd_addr = a;
    q1.push_back('{d: e, due: cyc + 1});
    @(negedge clk);
    rd_en1 = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (busy1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, 8);
    chk({name, "_lat2"}, {31'd0, busy2}, 32'd0);
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_rd_data1"}, rd_data1, 32'h0);
    chk({name, "_rd_valid1"}, {31'd0, rd_valid1}, 32'd0);
    chk({name, "_busy1"}, {31'd0, busy1}, 32'd1);
    chk({name, "_rd_data2"}, rd_data2, 32'h0);
    chk({name, "_rd_valid2"}, {31'd0, rd_valid2}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_coll_full, exp_coll_part;
`ifdef SDPB_RAM_BYPASS_EN
    exp_coll_full = 32'h11223344;
    exp_coll_part = 32'hAAAA3344;
`else
    exp_coll_full = 32'hAAAAAAAA;
    exp_coll_part = 32'hAAAAAAAA;
`endif

    // Power-on reset and clear
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_checks("por");
    reset = 1'b0;
    wait_busy("init_busy_cycles");

    // Back-to-back reads of all words, which must all be zero
    for (int i = 0; i < 8; i++) begin
      rd_en1 = 1'b1; rd_addr = 3'(i);
      q1.push_back('{d: 32'h0, due: cyc + 1});
      @(negedge clk);
    end
    rd_en1 = 1'b0;
    @(negedge clk);

    // Byte-enable merge
    wr(3'd3, 32'hDEADBEEF, 4'b1111);
    wr(3'd3, 32'h00005500, 4'b0010);
    rd1(3'd3, 32'hDEAD55EF);

    // Same-address collision, full and partial byte enables
    wr(3'd2, 32'hAAAAAAAA, 4'b1111);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h11223344; wr_be = 4'b1111;
    rd1(3'd2, exp_coll_full);
    wr_en = 1'b0;
    rd1(3'd2, 32'h11223344);
    wr(3'd2, 32'hAAAAAAAA, 4'b1111);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h11223344; wr_be = 4'b0011;
    rd1(3'd2, exp_coll_part);
    wr_en = 1'b0;
    rd1(3'd2, 32'hAAAA3344);
    @(negedge clk);

    // READ_LAT=2: read held in stage 1 for three oce-low edges
    wr(3'd5, 32'h0BADF00D, 4'b1111);
    rd_en2 = 1'b1; rd_addr = 3'd5; oce2 = 1'b0;
    q2.push_back('{d: 32'h0BADF00D, due: cyc + 4});
    @(negedge clk);
    rd_en2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    oce2 = 1'b1;
    repeat (3) @(negedge clk);

    // READ_LAT=2 with oce held high: two-cycle latency
    rd_en2 = 1'b1; rd_addr = 3'd3;
    q2.push_back('{d: 32'hDEAD55EF, due: cyc + 2});
    @(negedge clk);
    rd_en2 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset with nonzero outputs, requests during clear, reset mid-clear
    reset = 1'b1;
    #1 reset_checks("rst_async");
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
    rd_en1 = 1'b1; rd_en2 = 1'b1; rd_addr = 3'd6;
    repeat (4) @(negedge clk);
    wr_en = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0;
    chk("busy_mid_clear", {31'd0, busy1}, 32'd1);
    reset = 1'b1;
    #1 reset_checks("rst_mid_clear");
    @(negedge clk);
    reset = 1'b0;
    wait_busy("reclear_busy_cycles");

    for (int i = 0; i < 8; i++) begin
      rd_en1 = 1'b1; rd_addr = 3'(i);
      q1.push_back('{d: 32'h0, due: cyc + 1});
      @(negedge clk);
    end
    rd_en1 = 1'b0;
    repeat (4) @(negedge clk);

    chk("lat1_queue_drained", q1.size(), 32'd0);
    chk("lat2_queue_drained", q2.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
